cache_arbiter_rr: RTL and testbench
===================================

Name: cache_arbiter_rr

Overview:
- N-port round-robin arbiter between multiple requesters (CPU, accelerators) and a single shared cache port.
- A tagged in-order read-return FIFO routes each cache read response to the requester that issued it.
- Generalises the 2-port CPU/accelerator bus controller:
  - parametrised requester count, widths and FIFO depth;
  - FIFO-full backpressure that masks reads only;
  - correct simultaneous push/pop;
  - orphan-response error flag.
- Sits between the requester masters and the cache front end.

Parameters:
N_REQ, 2, number of requesters (2..8); index 0 is the CPU.
ADDR_W, 19, address width.
DATA_W, 256, data width; must be a multiple of 8.
RD_DEPTH, 4, maximum outstanding reads; power of 2, at least 2.

Ports:
clk_i  in  1  clock.
arst_i  in  1  asynchronous active-high reset.
req_valid  in  N_REQ  per-requester request valid.
req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
req_wdata  in  N_REQ*DATA_W  flattened write data.
req_wstrb  in  N_REQ*DATA_W/8  flattened byte strobes; all-zero means read.
req_ready  out  N_REQ  per-requester accept.
rsp_rdata  out  DATA_W  shared read data.
rsp_rvalid  out  N_REQ  per-requester read-data valid pulse.
cache_valid  out  1  request to cache.
cache_addr  out  ADDR_W  muxed address.
cache_wdata  out  DATA_W  muxed write data.
cache_wstrb  out  DATA_W/8  muxed strobes.
cache_rdata  in  DATA_W  cache read data.
cache_rvalid  in  1  cache read data valid.
cache_ready  in  1  cache accepts request.
rd_outstanding  out  clog2(RD_DEPTH)+1  current FIFO occupancy.
err_orphan  out  1  sticky: cache_rvalid arrived with the FIFO empty.

Behaviour:
- Handshake:
  - Requesters hold valid, addr, wdata and wstrb stable until req_ready.
  - A request transfers in the cycle where cache_valid && cache_ready.
- Eligibility:
  - eligible[i] = req_valid[i] && !(is_read[i] && fifo_full).
  - fifo_full = (count == RD_DEPTH).
  - The full check uses registered count only; a pop in the same cycle does not unblock a read.
  - Writes are never blocked by the FIFO.
- Grant (combinational): the first eligible index scanning from (last_grant+1) mod N_REQ upward with wrap.
  - No eligible requester: cache_valid=0 and all cache_* data outputs = 0.
- Outputs:
  - cache_* carry the granted requester's fields.
  - cache_valid = any eligible.
  - req_ready[g] = cache_ready for the granted index g; all other ready bits are 0.
- last_grant:
  - Updated to g on each accepted transfer; held otherwise.
  - Reset value N_REQ-1, so requester 0 wins first.
- Read FIFO:
  - On an accepted read, push g at tail; tail wraps mod RD_DEPTH.
- Response (one-cycle registered latency):
  - On cache_rvalid with count>0: next cycle rsp_rdata <= cache_rdata and rsp_rvalid[fifo[head]] = 1 for exactly one cycle; pop head.
  - rsp_rvalid is otherwise all 0.
  - rsp_rdata holds its last value between responses.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Orphan: cache_rvalid with count==0 → no pulse, no pointer change, err_orphan=1 until reset.
- Writes produce no response and no FIFO entry.
- Reset (async, any time, including mid-burst):
  - Values: head=tail=count=0, last_grant=N_REQ-1, rsp_rvalid=0, rsp_rdata=0, err_orphan=0.
  - In-flight reads are forgotten.
  - rd_outstanding = count.

Test Plan:
- Reset, then both requesters valid with reads for 4 cycles, cache_ready=1 → grants 0,1,0,1; rd_outstanding goes 1,2,3,4.
- RD_DEPTH=4: 4 reads outstanding, req0 read and req1 write both valid → req1 write accepted, req0 stalled; one cache_rvalid → req0 read accepted next cycle.
- Reads issued from 1,0,1, cache returns 0xA,0xB,0xC on consecutive cycles → rsp_rvalid[1]/0xA, then [0]/0xB, then [1]/0xC, each one cycle after cache_rvalid.
- Accepted read and cache_rvalid in the same cycle with count=2 → count stays 2 and the response goes to the oldest tag.
- cache_rvalid with the FIFO empty → err_orphan=1, sticky, no rsp_rvalid; cleared only by arst_i.
- N_REQ=3, all valid, cache_ready toggling 1,0,1,1 → grants 0,(hold 1),1,2; arst_i asserted with 2 reads outstanding clears count to 0 and rsp_rvalid to 0 immediately.

Source files
------------

// File: rtl/cache_arbiter_rr.sv
// Round-robin arbiter from N requesters onto one cache port. A tag FIFO records
// which requester issued each read so that in-order read data goes back to it.
module cache_arbiter_rr #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 256,
  parameter int RD_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_W-1:0]       req_addr,
  input  logic [N_REQ*DATA_W-1:0]       req_wdata,
  input  logic [N_REQ*(DATA_W/8)-1:0]   req_wstrb,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [N_REQ-1:0]              rsp_rvalid,
  output logic                          cache_valid,
  output logic [ADDR_W-1:0]             cache_addr,
  output logic [DATA_W-1:0]             cache_wdata,
  output logic [DATA_W/8-1:0]           cache_wstrb,
  input  logic [DATA_W-1:0]             cache_rdata,
  input  logic                          cache_rvalid,
  input  logic                          cache_ready,
  output logic [$clog2(RD_DEPTH):0]     rd_outstanding,
  output logic                          err_orphan
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(RD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TAG_W  = $clog2(N_REQ);

  logic [N_REQ-1:0]  is_read;
  logic [N_REQ-1:0]  eligible;
  logic              fifo_full;
  logic              grant_any;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  cand;
  logic              accept;
  logic              push;
  logic              pop;

  logic [TAG_W-1:0]  last_grant_q, last_grant_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N_REQ-1:0]  rsp_rvalid_q, rsp_rvalid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              err_orphan_q, err_orphan_d;
  logic [TAG_W-1:0]  fifo_q [RD_DEPTH];

  // The full test looks only at the registered count, so a same-cycle pop never unblocks a read.
  assign fifo_full = (count_q == CNT_W'(RD_DEPTH));

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign is_read[gi]  = ~|req_wstrb[gi*STRB_W +: STRB_W];
    assign eligible[gi] = req_valid[gi] & ~(is_read[gi] & fifo_full);
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = TAG_W'((int'(last_grant_q) + k) % N_REQ);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    cache_valid = grant_any;
    cache_addr  = '0;
    cache_wdata = '0;
    cache_wstrb = '0;
    req_ready   = '0;
    if (grant_any) begin
      cache_addr           = req_addr[grant_idx*ADDR_W +: ADDR_W];
      cache_wdata          = req_wdata[grant_idx*DATA_W +: DATA_W];
      cache_wstrb          = req_wstrb[grant_idx*STRB_W +: STRB_W];
      req_ready[grant_idx] = cache_ready;
    end
  end

  assign accept = grant_any & cache_ready;
  assign push   = accept & is_read[grant_idx];
  assign pop    = cache_rvalid & (count_q != '0);

  always_comb begin
    last_grant_d = accept ? grant_idx : last_grant_q;
    head_d       = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d       = push ? tail_q + PTR_W'(1) : tail_q;
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    rsp_rvalid_d = '0;
    rsp_rdata_d  = rsp_rdata_q;
    if (pop) begin
      rsp_rvalid_d[fifo_q[head_q]] = 1'b1;
      rsp_rdata_d                  = cache_rdata;
    end
    err_orphan_d = err_orphan_q | (cache_rvalid & (count_q == '0));
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      last_grant_q <= TAG_W'(N_REQ - 1);
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rsp_rvalid_q <= '0;
      rsp_rdata_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rsp_rvalid_q <= rsp_rvalid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag storage needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[tail_q] <= grant_idx;
    end
  end

  assign rsp_rvalid     = rsp_rvalid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rd_outstanding = count_q;
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Directed bench: a 2-requester instance (A) and a 3-requester instance (B)
// share clock and reset; each step checks hand-computed expectations.
module tb_cache_arbiter_rr;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: N_REQ=2
  logic [1:0]  a_valid;
  logic [15:0] a_addr;
  logic [63:0] a_wdata;
  logic [7:0]  a_wstrb;
  logic [1:0]  a_ready;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_rsp_rvalid;
  logic        a_cvalid;
  logic [7:0]  a_caddr;
  logic [31:0] a_cwdata;
  logic [3:0]  a_cwstrb;
  logic [31:0] a_crdata;
  logic        a_crvalid;
  logic        a_cready;
  logic [2:0]  a_outst;
  logic        a_orphan;

  // Instance B: N_REQ=3
  logic [2:0]  b_valid;
  logic [23:0] b_addr;
  logic [95:0] b_wdata;
  logic [11:0] b_wstrb;
  logic [2:0]  b_ready;
  logic [31:0] b_rsp_rdata;
  logic [2:0]  b_rsp_rvalid;
  logic        b_cvalid;
  logic [7:0]  b_caddr;
  logic [31:0] b_cwdata;
  logic [3:0]  b_cwstrb;
  logic [31:0] b_crdata;
  logic        b_crvalid;
  logic        b_cready;
  logic [2:0]  b_outst;
  logic        b_orphan;

  cache_arbiter_rr #(.N_REQ(2), .ADDR_W(8), .DATA_W(32), .RD_DEPTH(4)) dut_a (
    .clk_i(clk), .arst_i(arst),
    .req_valid(a_valid), .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
    .req_ready(a_ready), .rsp_rdata(a_rsp_rdata), .rsp_rvalid(a_rsp_rvalid),
    .cache_valid(a_cvalid), .cache_addr(a_caddr), .cache_wdata(a_cwdata), .cache_wstrb(a_cwstrb),
    .cache_rdata(a_crdata), .cache_rvalid(a_crvalid), .cache_ready(a_cready),
    .rd_outstanding(a_outst), .err_orphan(a_orphan)
  );

  cache_arbiter_rr #(.N_REQ(3), .ADDR_W(8), .DATA_W(32), .RD_DEPTH(4)) dut_b (
    .clk_i(clk), .arst_i(arst),
    .req_valid(b_valid), .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
    .req_ready(b_ready), .rsp_rdata(b_rsp_rdata), .rsp_rvalid(b_rsp_rvalid),
    .cache_valid(b_cvalid), .cache_addr(b_caddr), .cache_wdata(b_cwdata), .cache_wstrb(b_cwstrb),
    .cache_rdata(b_crdata), .cache_rvalid(b_crvalid), .cache_ready(b_cready),
    .rd_outstanding(b_outst), .err_orphan(b_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst      = 1'b1;
    a_valid   = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    a_crdata  = '0; a_crvalid = 1'b0; a_cready = 1'b1;
    b_valid   = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    b_crdata  = '0; b_crvalid = 1'b0; b_cready = 1'b1;
    #12;
    arst = 1'b0;
    #2;
    chk("rst_outst", 64'(a_outst), 64'd0);
    chk("rst_orphan", 64'(a_orphan), 64'd0);
    chk("rst_rvalid", 64'(a_rsp_rvalid), 64'd0);
    chk("rst_rdata", 64'(a_rsp_rdata), 64'd0);
    chk("rst_cvalid", 64'(a_cvalid), 64'd0);
    chk("rst_caddr", 64'(a_caddr), 64'd0);
    tick();

    // Both requesters read continuously: grants alternate 0,1,0,1.
    a_valid = 2'b11; a_addr = {8'h21, 8'h10};
    #3;
    chk("rr0_ready", 64'(a_ready), 64'b01);
    chk("rr0_addr", 64'(a_caddr), 64'h10);
    tick(); chk("rr0_outst", 64'(a_outst), 64'd1);
    #3;
    chk("rr1_ready", 64'(a_ready), 64'b10);
    chk("rr1_addr", 64'(a_caddr), 64'h21);
    tick(); chk("rr1_outst", 64'(a_outst), 64'd2);
    #3;
    chk("rr2_ready", 64'(a_ready), 64'b01);
    tick(); chk("rr2_outst", 64'(a_outst), 64'd3);
    #3;
    chk("rr3_ready", 64'(a_ready), 64'b10);
    tick(); chk("rr3_outst", 64'(a_outst), 64'd4);

    // FIFO full: req0 read blocked, req1 write still goes through.
    a_wstrb = 8'hF0; a_wdata = {32'hDEAD_BEEF, 32'h0};
    #3;
    chk("full_wr_ready", 64'(a_ready), 64'b10);
    chk("full_wr_wdata", 64'(a_cwdata), 64'hDEAD_BEEF);
    chk("full_wr_wstrb", 64'(a_cwstrb), 64'hF);
    tick(); chk("full_wr_outst", 64'(a_outst), 64'd4);
    a_valid = 2'b01; a_wstrb = '0; a_wdata = '0;
    a_crvalid = 1'b1; a_crdata = 32'h111;
    #3;
    chk("full_stall_cvalid", 64'(a_cvalid), 64'd0);
    chk("full_stall_ready", 64'(a_ready), 64'b00);
    tick();
    a_crvalid = 1'b0;
    chk("pop_rvalid", 64'(a_rsp_rvalid), 64'b01);
    chk("pop_rdata", 64'(a_rsp_rdata), 64'h111);
    chk("pop_outst", 64'(a_outst), 64'd3);
    #3;
    chk("unblk_ready", 64'(a_ready), 64'b01);
    tick(); chk("unblk_outst", 64'(a_outst), 64'd4);
    a_valid = 2'b00;

    // Remaining tags in order 1,0,1,0.
    a_crvalid = 1'b1; a_crdata = 32'hA;
    tick(); chk("ret_a_rvalid", 64'(a_rsp_rvalid), 64'b10); chk("ret_a_rdata", 64'(a_rsp_rdata), 64'hA);
    a_crdata = 32'hB;
    tick(); chk("ret_b_rvalid", 64'(a_rsp_rvalid), 64'b01); chk("ret_b_rdata", 64'(a_rsp_rdata), 64'hB);
    a_crdata = 32'hC;
    tick(); chk("ret_c_rvalid", 64'(a_rsp_rvalid), 64'b10); chk("ret_c_rdata", 64'(a_rsp_rdata), 64'hC);
    a_crdata = 32'hD;
    tick(); chk("ret_d_rvalid", 64'(a_rsp_rvalid), 64'b01); chk("ret_d_outst", 64'(a_outst), 64'd0);
    a_crvalid = 1'b0;
    tick();
    chk("idle_rvalid", 64'(a_rsp_rvalid), 64'b00);
    chk("hold_rdata", 64'(a_rsp_rdata), 64'hD);
    chk("idle_orphan", 64'(a_orphan), 64'd0);

    // last_grant=0: two reads go to 1 then 0, then push+pop in the same cycle.
    a_valid = 2'b11;
    #3; chk("pp_g1", 64'(a_ready), 64'b10);
    tick();
    #3; chk("pp_g0", 64'(a_ready), 64'b01);
    tick(); chk("pp_cnt2", 64'(a_outst), 64'd2);
    a_valid = 2'b10; a_crvalid = 1'b1; a_crdata = 32'hE;
    #3; chk("pp_ready", 64'(a_ready), 64'b10);
    tick();
    chk("pp_outst", 64'(a_outst), 64'd2);
    chk("pp_rvalid", 64'(a_rsp_rvalid), 64'b10);
    chk("pp_rdata", 64'(a_rsp_rdata), 64'hE);
    a_valid = 2'b00; a_crdata = 32'h21;
    tick(); chk("pp_d0_rvalid", 64'(a_rsp_rvalid), 64'b01);
    a_crdata = 32'h22;
    tick(); chk("pp_d1_rvalid", 64'(a_rsp_rvalid), 64'b10); chk("pp_d1_outst", 64'(a_outst), 64'd0);

    // Orphan response with empty FIFO.
    a_crdata = 32'hF;
    tick();
    a_crvalid = 1'b0;
    chk("orph_flag", 64'(a_orphan), 64'd1);
    chk("orph_rvalid", 64'(a_rsp_rvalid), 64'b00);
    chk("orph_rdata", 64'(a_rsp_rdata), 64'h22);
    chk("orph_outst", 64'(a_outst), 64'd0);
    tick(); tick();
    chk("orph_sticky", 64'(a_orphan), 64'd1);

    // Instance B: cache_ready 1,0,1,1 gives grants 0, hold 1, 1, 2.
    b_valid = 3'b111; b_addr = {8'h32, 8'h31, 8'h30};
    b_cready = 1'b1;
    #3; chk("b_g0_ready", 64'(b_ready), 64'b001);
    tick();
    b_cready = 1'b0;
    #3; chk("b_hold_ready", 64'(b_ready), 64'b000); chk("b_hold_addr", 64'(b_caddr), 64'h31);
    tick(); chk("b_hold_outst", 64'(b_outst), 64'd1);
    b_cready = 1'b1;
    #3; chk("b_g1_ready", 64'(b_ready), 64'b010);
    tick();
    #3; chk("b_g2_ready", 64'(b_ready), 64'b100); chk("b_g2_addr", 64'(b_caddr), 64'h32);
    tick(); chk("b_outst3", 64'(b_outst), 64'd3);
    b_valid = 3'b000; b_crvalid = 1'b1; b_crdata = 32'h55;
    tick();
    b_crvalid = 1'b0;
    chk("b_pop_rvalid", 64'(b_rsp_rvalid), 64'b001);
    chk("b_pop_outst", 64'(b_outst), 64'd2);

    // Asynchronous reset mid-cycle clears state immediately.
    #2;
    arst = 1'b1;
    #1;
    chk("b_arst_outst", 64'(b_outst), 64'd0);
    chk("b_arst_rvalid", 64'(b_rsp_rvalid), 64'b000);
    chk("b_arst_rdata", 64'(b_rsp_rdata), 64'd0);
    chk("a_arst_orphan", 64'(a_orphan), 64'd0);
    #10;
    arst = 1'b0;
    tick();
    chk("a_post_orphan", 64'(a_orphan), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
